// File: rtl/router_link_pkg.sv
// router_link_pkg: frame field positions, link widths and rx FSM states shared by the
// Aurora link serializer and deserializer.
package router_link_pkg;
    localparam int AURORA_DATA_WIDTH = 64;
    localparam int SEND_DATA_WIDTH = 1024;
    localparam int RECOGNIZE_HEADER_WIDTH = 1;
    localparam int RECOGNIZE_ROUTER_WIDTH = 2;
    localparam int HOST_PAYLOAD_WIDTH = AURORA_DATA_WIDTH - 3;
    localparam int NUMBER_PACKET = SEND_DATA_WIDTH / HOST_PAYLOAD_WIDTH + 1;
    localparam int ADDR_WIDTH = 10;
    localparam int TTL_WIDTH = 2;
    localparam int HDR_BIT = 0;
    localparam int ID_LSB = 1;
    localparam int DST_LSB = 3;
    localparam int TTL_LSB = DST_LSB + ADDR_WIDTH;
    localparam int PAYLOAD_LSB = RECOGNIZE_HEADER_WIDTH + RECOGNIZE_ROUTER_WIDTH;
    // Frames 0..NUMBER_PACKET-2 fill the body; the final frame carries only the remainder.
    localparam int BODY_WIDTH = (NUMBER_PACKET - 1) * HOST_PAYLOAD_WIDTH;
    localparam int LAST_WIDTH = SEND_DATA_WIDTH - BODY_WIDTH;
    localparam int COUNT_WIDTH = $clog2(NUMBER_PACKET + 1);
    typedef enum logic {IDLE, PAYLOAD} rx_state_t;
endpackage

// File: rtl/deserializer_rx_if.sv
// deserializer_rx_if: Aurora RX AXI-Stream beat (no tready), driven by the link core.
interface deserializer_rx_if;
    import router_link_pkg::*;
    logic tvalid;
    logic tlast;
    logic [AURORA_DATA_WIDTH-1:0] tdata;
    modport master (output tvalid, tlast, tdata);
    modport slave (input tvalid, tlast, tdata);
endinterface

// File: rtl/deserializer_rx.sv
// deserializer_rx: reassembles a header frame plus NUMBER_PACKET payload frames into one
// word, pulsing recv_data_valid for good packets and frame_err for dropped ones.
module deserializer_rx
    import router_link_pkg::*;
(
    input  logic clk,
    input  logic rst,
    deserializer_rx_if.slave axis_rx,
    output logic recv_data_valid,
    output logic [SEND_DATA_WIDTH-1:0] v_data_recv,
    output logic [ADDR_WIDTH-1:0] dst_addr_recv,
    output logic [TTL_WIDTH-1:0] TTL_recv,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
    output logic frame_err
);
    rx_state_t state, state_next;
    logic [COUNT_WIDTH-1:0] frame_count;
    logic [BODY_WIDTH-1:0] body;
    logic [ADDR_WIDTH-1:0] dst;
    logic [TTL_WIDTH-1:0] ttl;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] id;
    logic last_k, hdr_take, pay_ok, done, store, err;

    assign last_k = frame_count == COUNT_WIDTH'(NUMBER_PACKET - 1);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_comb
        state_next = !axis_rx.tvalid ? state : (hdr_take || store) ? PAYLOAD : IDLE;

    // A header arriving mid-packet aborts the old packet but still opens the new one.
    always_comb begin
        hdr_take = axis_rx.tvalid && axis_rx.tdata[HDR_BIT] && !axis_rx.tlast;
        pay_ok = axis_rx.tvalid && state == PAYLOAD && !axis_rx.tdata[HDR_BIT]
            && axis_rx.tdata[ID_LSB +: RECOGNIZE_ROUTER_WIDTH] == id && axis_rx.tlast == last_k;
        done = pay_ok && last_k;
        store = pay_ok && !last_k;
        err = axis_rx.tvalid && !(hdr_take && state == IDLE) && !pay_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            body <= '0;
            dst <= '0;
            ttl <= '0;
            id <= '0;
            recv_data_valid <= 1'b0;
            frame_err <= 1'b0;
            v_data_recv <= '0;
            dst_addr_recv <= '0;
            TTL_recv <= '0;
            router_id_recv <= '0;
        end else begin
            recv_data_valid <= done;
            frame_err <= err;
            if (hdr_take) begin
                dst <= axis_rx.tdata[DST_LSB +: ADDR_WIDTH];
                ttl <= axis_rx.tdata[TTL_LSB +: TTL_WIDTH];
                id <= axis_rx.tdata[ID_LSB +: RECOGNIZE_ROUTER_WIDTH];
                frame_count <= '0;
            end
            if (store) begin
                body[frame_count * HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH] <= axis_rx.tdata[PAYLOAD_LSB +: HOST_PAYLOAD_WIDTH];
                frame_count <= frame_count + 1'b1;
            end
            if (done) begin
                v_data_recv <= {axis_rx.tdata[PAYLOAD_LSB +: LAST_WIDTH], body};
                dst_addr_recv <= dst;
                TTL_recv <= ttl;
                router_id_recv <= id;
            end
        end
    end
endmodule

// File: tb/tb_deserializer_rx.sv
// tb_deserializer_rx: table of packets (good and faulted) serialized onto the RX stream,
// with a scoreboard queue of expected result/error pulses.
module tb_deserializer_rx;
    import router_link_pkg::*;

    typedef struct {
        logic [SEND_DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] dst;
        logic [TTL_WIDTH-1:0] ttl;
        logic [1:0] id;
        int gap;
        int fault;
        int f;
        logic [1:0] bad_id;
        bit good;
    } vec_t;

    typedef struct {
        bit good;
        logic [SEND_DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] dst;
        logic [TTL_WIDTH-1:0] ttl;
        logic [1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic recv_data_valid, frame_err;
    logic [SEND_DATA_WIDTH-1:0] v_data_recv;
    logic [ADDR_WIDTH-1:0] dst_addr_recv;
    logic [TTL_WIDTH-1:0] TTL_recv;
    logic [1:0] router_id_recv;
    exp_t q[$];
    exp_t held;
    exp_t err_e;
    exp_t pop_e;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    deserializer_rx_if axis_rx();

    deserializer_rx dut (
        .clk(clk),
        .rst(rst),
        .axis_rx(axis_rx.slave),
        .recv_data_valid(recv_data_valid),
        .v_data_recv(v_data_recv),
        .dst_addr_recv(dst_addr_recv),
        .TTL_recv(TTL_recv),
        .router_id_recv(router_id_recv),
        .frame_err(frame_err)
    );

    task automatic chk(string name, logic [SEND_DATA_WIDTH-1:0] act, logic [SEND_DATA_WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic chk_held(string tag);
        chk({tag, "_data"}, v_data_recv, held.data);
        chk({tag, "_dst"}, SEND_DATA_WIDTH'(dst_addr_recv), SEND_DATA_WIDTH'(held.dst));
        chk({tag, "_ttl"}, SEND_DATA_WIDTH'(TTL_recv), SEND_DATA_WIDTH'(held.ttl));
        chk({tag, "_id"}, SEND_DATA_WIDTH'(router_id_recv), SEND_DATA_WIDTH'(held.id));
    endtask

    always @(negedge clk) begin
        if (!rst && (recv_data_valid || frame_err)) begin
            chk("exclusive", SEND_DATA_WIDTH'(recv_data_valid & frame_err), '0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b want none", recv_data_valid, frame_err);
            end else begin
                pop_e = q.pop_front();
                chk("pulse_kind", SEND_DATA_WIDTH'(recv_data_valid), SEND_DATA_WIDTH'(pop_e.good));
                if (pop_e.good) held = pop_e;
                chk_held("pulse");
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            axis_rx.tvalid = 1'b0;
            axis_rx.tlast = 1'b0;
            axis_rx.tdata = {$urandom, $urandom};
        end
    endtask

    task automatic beat(logic l, logic [AURORA_DATA_WIDTH-1:0] d);
        @(negedge clk);
        axis_rx.tvalid = 1'b1;
        axis_rx.tlast = l;
        axis_rx.tdata = d;
    endtask

    task automatic chk_zero();
        chk("rst_valid", SEND_DATA_WIDTH'(recv_data_valid), '0);
        chk("rst_err", SEND_DATA_WIDTH'(frame_err), '0);
        held = '{default: '0};
        chk_held("rst");
    endtask

    task automatic send(vec_t v);
        logic [NUMBER_PACKET*HOST_PAYLOAD_WIDTH-1:0] ext;
        logic l;
        ext = (NUMBER_PACKET*HOST_PAYLOAD_WIDTH)'(v.data);
        if (v.fault == 5) begin
            beat(1'b0, {v.data[60:0], v.id, 1'b0});
            q.push_back(err_e);
            return;
        end
        beat(1'b0, {49'h0, v.ttl, v.dst, v.id, 1'b1});
        for (int k = 0; k < NUMBER_PACKET; k++) begin
            idle($urandom_range(0, v.gap));
            if (v.fault == 2 && k == v.f) begin
                q.push_back(err_e);
                return;
            end
            if (v.fault == 4 && k == v.f) begin
                @(negedge clk);
                rst = 1'b1;
                axis_rx.tvalid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk_zero();
                return;
            end
            l = (k == NUMBER_PACKET - 1 && v.fault != 6) || (v.fault == 1 && k == v.f);
            beat(l, {ext[k*HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH], (v.fault == 3 && k == v.f) ? v.bad_id : v.id, 1'b0});
            if ((v.fault == 1 || v.fault == 3 || v.fault == 6) && k == v.f) begin
                q.push_back(err_e);
                return;
            end
        end
        q.push_back('{v.good, v.data, v.dst, v.ttl, v.id});
    endtask

    initial begin
        vec_t tv[13];
        logic [SEND_DATA_WIDTH-1:0] pat, r1, r2, fives;
        for (int i = 0; i < SEND_DATA_WIDTH / 4; i++) pat[i*4 +: 4] = 4'(9 - (i / 4) % 9);
        for (int i = 0; i < SEND_DATA_WIDTH / 32; i++) begin
            r1[i*32 +: 32] = $urandom;
            r2[i*32 +: 32] = $urandom;
        end
        fives = {256{4'h5}};
        err_e = '{default: '0};
        held = '{default: '0};
        tv[0]  = '{pat,   10'h00A, 2'b01, 2'b10, 0, 0, 0,  2'b00, 1'b1};
        tv[1]  = '{fives, 10'h1AA, 2'b10, 2'b11, 3, 0, 0,  2'b00, 1'b1};
        tv[2]  = '{fives, 10'h1AA, 2'b10, 2'b11, 0, 0, 0,  2'b00, 1'b1};
        tv[3]  = '{r1,    10'h3C3, 2'b11, 2'b00, 1, 1, 9,  2'b00, 1'b0};
        tv[4]  = '{~pat,  10'h200, 2'b11, 2'b01, 0, 0, 0,  2'b00, 1'b1};
        tv[5]  = '{r2,    10'h077, 2'b00, 2'b10, 0, 3, 4,  2'b01, 1'b0};
        tv[6]  = '{r1,    10'h000, 2'b00, 2'b01, 0, 5, 0,  2'b00, 1'b0};
        tv[7]  = '{r2,    10'h111, 2'b01, 2'b10, 0, 2, 6,  2'b00, 1'b0};
        tv[8]  = '{r2,    10'h155, 2'b10, 2'b10, 2, 0, 0,  2'b00, 1'b1};
        tv[9]  = '{r1,    10'h2AA, 2'b01, 2'b10, 0, 4, 8,  2'b00, 1'b0};
        tv[10] = '{r1,    10'h0F0, 2'b01, 2'b01, 1, 0, 0,  2'b00, 1'b1};
        tv[11] = '{pat,   10'h001, 2'b10, 2'b11, 0, 6, 16, 2'b00, 1'b0};
        tv[12] = '{'1,    10'h3FF, 2'b11, 2'b11, 0, 0, 0,  2'b00, 1'b1};
        axis_rx.tvalid = 1'b0;
        axis_rx.tlast = 1'b0;
        axis_rx.tdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero();
        foreach (tv[i]) send(tv[i]);
        for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        idle(3);
        chk_held("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
